pc_predict_unit: RTL
====================

Name: pc_predict_unit

Overview:
- Parametrised fetch-stage PC generator for the pipelined core. It is the successor to the single-cycle PC register and next-PC mux.
- Holds the architectural fetch PC and supports stall and execute-stage redirect.
- Adds a direct-mapped branch target buffer (BTB) with 2-bit saturating counters, so taken branches and jumps are predicted in fetch.

Parameters:
XLEN, 32, PC/address width
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
BTB_ENTRIES, 16, BTB entry count; power of two, >= 2
INSTR_BYTES, 4, fetch increment in bytes

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
stall_i  in  1  hold PC (fetch/decode stall)
redirect_i  in  1  execute-stage correction (mispredict, JALR, trap)
redirect_pc_i  in  XLEN  corrected next PC
update_valid_i  in  1  resolved control-flow instruction in execute
update_pc_i  in  XLEN  PC of resolved instruction
update_target_i  in  XLEN  resolved target address
update_taken_i  in  1  resolved direction
pc_o  in/out: out  XLEN  current fetch PC
pc_plus4_o  out  XLEN  pc_o + INSTR_BYTES
pred_taken_o  out  1  BTB predicts taken for pc_o
pred_target_o  out  XLEN  predicted next PC

Behaviour:
- Reset (async, rst=1):
  - pc_o = RESET_VECTOR.
  - All BTB valid bits = 0; all counters = WNT (2'b01).
  - Outputs settle combinationally: pred_taken_o = 0, pred_target_o = RESET_VECTOR + INSTR_BYTES.
- Address fields:
  - IDX_W = log2(BTB_ENTRIES).
  - index = pc[IDX_W+1:2].
  - tag = pc[XLEN-1:IDX_W+2].
  - pc[1:0] is ignored for lookup and update.
- Lookup (combinational on pc_o, zero latency):
  - hit = valid[index] & tag match.
  - pred_taken_o = hit & ctr[1].
  - pred_target_o = stored target if pred_taken_o, else pc_plus4_o.
- Next PC, registered on the rising edge, in priority order:
  1. redirect_i → redirect_pc_i. Overrides stall_i.
  2. stall_i → hold pc_o.
  3. Otherwise → pred_target_o.
- Arithmetic: pc_plus4_o wraps modulo 2^XLEN (e.g. 32'hFFFF_FFFC → 0). Alignment checking is not done here.
- BTB update (synchronous, when update_valid_i = 1, at the index/tag of update_pc_i). Proceeds regardless of stall_i and redirect_i.
  - Hit, taken: counter increments, saturating at ST (2'b11); stored target = update_target_i.
  - Hit, not taken: counter decrements, saturating at SNT (2'b00); target unchanged.
  - Miss, taken: allocate. valid = 1, tag written, target = update_target_i, counter = WT (2'b10). Replaces any existing entry at that index.
  - Miss, not taken: no change.
- Same-cycle lookup and update to the same index: lookup uses pre-update contents (no bypass). The new state is visible the next cycle.
- Reset asserted mid-operation clears everything immediately. A pending update on that edge is discarded.
- No internal X-propagation: all storage is reset, so outputs are fully defined after reset.

Decomposition:
- Package pc_pkg holds:
  - enum ctr_t {SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11};
  - saturating inc/dec functions;
  - a BTB entry struct (valid, tag, target, ctr), parametrised via localparam widths in the module.
- One sub-module, pc_btb: the storage array, combinational lookup port, and synchronous update port.
- Next-PC selection and the PC register stay in pc_predict_unit.

Test Plan:
- Reset and sequential fetch: rst pulse, then 4 idle cycles → pc_o goes 0x0, 0x4, 0x8, 0xC; pred_taken_o = 0 throughout.
- Stall versus redirect: stall_i = 1 at pc 0x10 for 3 cycles → pc_o holds 0x10. Then stall_i = 1 with redirect_i = 1 and redirect_pc_i = 0x200 → next pc_o = 0x200.
- Train and predict: update 0x20 → target 0x100, taken. When pc_o reaches 0x20 → pred_taken_o = 1, pred_target_o = 0x100, and the next pc_o = 0x100.
- Counter hysteresis: from WT, apply two not-taken updates at 0x20 → counter goes WNT then SNT, and the lookup at 0x20 gives pred_taken_o = 0. Then three taken updates → counter reaches ST and stays there (saturates).
- Aliasing and same-cycle update: with BTB_ENTRIES = 16, 0x20 allocated, then update 0x420 taken → 0x20 misses and 0x420 hits. While pc_o = 0x420 and an update at 0x420 is applied, the lookup in that cycle shows the old entry.
- Wrap and async reset: redirect to 0xFFFF_FFFC → pc_plus4_o = 0 and the next pc_o = 0. Asserting rst between clock edges → pc_o = RESET_VECTOR immediately and all BTB entries miss.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types and helpers for the fetch-stage PC predictor.
package pc_pkg;

  // 2-bit saturating branch direction counter
  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

  // Step the counter towards strongly-taken, saturating at ST
  function automatic ctr_t ctr_inc(input ctr_t c);
    case (c)
      SNT:     return WNT;
      WNT:     return WT;
      default: return ST;
    endcase
  endfunction

  // Step the counter towards strongly-not-taken, saturating at SNT
  function automatic ctr_t ctr_dec(input ctr_t c);
    case (c)
      ST:      return WT;
      WT:      return WNT;
      default: return SNT;
    endcase
  endfunction

endpackage

// File: rtl/pc_btb.sv
// Direct-mapped branch target buffer: combinational lookup, synchronous update.
module pc_btb
  import pc_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned BTB_ENTRIES = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] lookup_pc,
  output logic            lookup_taken,
  output logic [XLEN-1:0] lookup_target,
  input  logic            update_valid,
  input  logic [XLEN-1:0] update_pc,
  input  logic [XLEN-1:0] update_target,
  input  logic            update_taken
);

  localparam int unsigned IDX_W = $clog2(BTB_ENTRIES);
  localparam int unsigned TAG_W = XLEN - IDX_W - 2;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  target;
    ctr_t             ctr;
  } btb_entry_t;

  btb_entry_t mem [BTB_ENTRIES];

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  btb_entry_t       lk_e, up_e;
  logic             up_hit;
  logic             unused_lsbs;

  assign lk_idx = lookup_pc[IDX_W+1:2];
  assign lk_tag = lookup_pc[XLEN-1:IDX_W+2];
  assign up_idx = update_pc[IDX_W+1:2];
  assign up_tag = update_pc[XLEN-1:IDX_W+2];

  // Byte offset within the instruction word plays no part in lookup or update
  assign unused_lsbs = ^{lookup_pc[1:0], update_pc[1:0]};

  // Lookup reads pre-update contents; there is no bypass from the update port
  always_comb begin
    lk_e          = mem[lk_idx];
    lookup_taken  = lk_e.valid && (lk_e.tag == lk_tag) && lk_e.ctr[1];
    lookup_target = lk_e.target;
  end

  // Hit detection for the update port
  always_comb begin
    up_e   = mem[up_idx];
    up_hit = up_e.valid && (up_e.tag == up_tag);
  end

  // Storage: async clear, then train counters / allocate on resolved branches
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < BTB_ENTRIES; i++) begin
        mem[i].valid  <= 1'b0;
        mem[i].tag    <= '0;
        mem[i].target <= '0;
        mem[i].ctr    <= WNT;
      end
    end else if (update_valid) begin
      if (up_hit) begin
        if (update_taken) begin
          mem[up_idx].ctr    <= ctr_inc(up_e.ctr);
          mem[up_idx].target <= update_target;
        end else begin
          mem[up_idx].ctr <= ctr_dec(up_e.ctr);
        end
      end else if (update_taken) begin
        mem[up_idx].valid  <= 1'b1;
        mem[up_idx].tag    <= up_tag;
        mem[up_idx].target <= update_target;
        mem[up_idx].ctr    <= WT;
      end
    end
  end

endmodule

// File: rtl/pc_predict_unit.sv
// Fetch-stage PC generator with BTB-based next-PC prediction.
module pc_predict_unit
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int unsigned     BTB_ENTRIES  = 16,
  parameter int unsigned     INSTR_BYTES  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            update_valid_i,
  input  logic [XLEN-1:0] update_pc_i,
  input  logic [XLEN-1:0] update_target_i,
  input  logic            update_taken_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus4_o,
  output logic            pred_taken_o,
  output logic [XLEN-1:0] pred_target_o
);

  localparam logic [XLEN-1:0] STEP = XLEN'(INSTR_BYTES);

  logic [XLEN-1:0] btb_target;
  logic [XLEN-1:0] next_pc;

  pc_btb #(
    .XLEN        (XLEN),
    .BTB_ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk           (clk),
    .rst           (rst),
    .lookup_pc     (pc_o),
    .lookup_taken  (pred_taken_o),
    .lookup_target (btb_target),
    .update_valid  (update_valid_i),
    .update_pc     (update_pc_i),
    .update_target (update_target_i),
    .update_taken  (update_taken_i)
  );

  // Sequential successor wraps modulo 2^XLEN; prediction overrides it on a BTB hit
  always_comb begin
    pc_plus4_o    = pc_o + STEP;
    pred_target_o = pred_taken_o ? btb_target : pc_plus4_o;
  end

  // Next-PC priority: redirect, then stall, then predicted target
  always_comb begin
    next_pc = pred_target_o;
    if (redirect_i) begin
      next_pc = redirect_pc_i;
    end else if (stall_i) begin
      next_pc = pc_o;
    end
  end

  // Architectural fetch PC register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_o <= RESET_VECTOR;
    end else begin
      pc_o <= next_pc;
    end
  end

endmodule
